// File: rtl/dmem_line_model.sv
// rtl/dmem_line_model.sv - line-wide data memory with fixed access latency
// Captures each request at acceptance; completes with a one-cycle ack after LATENCY clocks.
module dmem_line_model #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned LINES   = 512,
  parameter int unsigned LINE_AW = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic [255:0] data_o,
  output logic         ack_o,
  output logic         busy_o,
  output logic [31:0]  rd_cnt_o,
  output logic [31:0]  wr_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 wr_q;
  logic [LINE_AW-1:0]   idx_q;
  logic [255:0]         wdata_q;
  logic [255:0]         data_q;
  logic [31:0]          rd_cnt_q, wr_cnt_q;
  logic                 accept;
  logic                 complete;
  logic [255:0]         mem_q [LINES];

  // Offset bits and aliased upper bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:LINE_AW+5], addr_i[4:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          accept  = 1'b1;
          state_d = S_WAIT;
          cnt_d   = 8'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          complete = 1'b1;
          state_d  = S_ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= write_i;
        idx_q   <= addr_i[LINE_AW+4:5];
        wdata_q <= data_i;
      end
      if (complete) begin
        if (wr_q) begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
          data_q   <= mem_q[idx_q];
          rd_cnt_q <= rd_cnt_q + 32'd1;
        end
      end
    end
  end

  // Array has no reset; a reset clears state_q, so an unfinished write never lands.
  always_ff @(posedge clk_i) begin
    if (complete && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign data_o   = data_q;
  assign ack_o    = (state_q == S_ACK);
  assign busy_o   = (state_q != S_IDLE);
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;

endmodule
